qed_writeback_checker: RTL and testbench
========================================

Name: qed_writeback_checker

Overview:
- Consumes the retire stream of a dual-issue core running QED-duplicated code.
- Original instructions write x1..x15. Duplicates, produced by the instruction-modify stage, write x16..x31.
- Queues each original register writeback and matches it, in program order, against the next duplicate writeback.
- Raises a sticky error on value/register mismatch, queue overflow or an orphan duplicate. Sits beside the register-file write ports as the end-of-chain QED checker.

Parameters:
DEPTH, 8, pending-original queue entries (power of two, >=2)
XLEN, 32, writeback data width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
qed_ena_i  in  1  checking enabled; when low, retires are ignored
ret0_valid_i  in  1  slot-0 retire with register writeback (older of the pair)
ret0_rd_i  in  5  slot-0 destination register
ret0_data_i  in  XLEN  slot-0 writeback value
ret1_valid_i  in  1  slot-1 retire with register writeback (younger)
ret1_rd_i  in  5  slot-1 destination register
ret1_data_i  in  XLEN  slot-1 writeback value
clear_i  in  1  flush queue and clear error (software re-arm)
qed_error_o  out  1  sticky error flag
qed_err_code_o  out  2  0 none, 1 mismatch, 2 overflow, 3 orphan duplicate
qed_err_rd_o  out  5  rd of the offending duplicate or original
pending_o  out  $clog2(DEPTH)+1  queued originals awaiting a duplicate
qed_consistent_o  out  1  pending_o==0 and no error

Behaviour:
- Reset (rst_ni low at clk_i edge): queue empty, pending_o=0, qed_error_o=0, qed_err_code_o=0, qed_err_rd_o=0, qed_consistent_o=1.
- Reset and clear_i take effect the same cycle. Reset mid-stream discards all entries.
- Classification per valid slot with qed_ena_i=1:
  - rd==0: ignored.
  - rd[4]==0: original → push {rd[3:0], data}.
  - rd[4]==1: duplicate → pop and compare.
- qed_ena_i=0: no push, pop or error update. Queue contents are held.
- Compare rule: duplicate matches if popped rd[3:0]==dup rd[3:0] and popped data==dup data.
- Intra-cycle ordering: slot 0 is processed before slot 1.
  - Slot 0 original, slot 1 duplicate, queue empty: slot 1 compares directly against slot 0 (bypass), and nothing is stored.
  - Otherwise slot 1's duplicate compares against the queue head. Slot 0's original is pushed behind any existing entries.
  - Both duplicates: pop two. Slot 0 takes the head, slot 1 the next entry.
  - Both originals: push two. This requires two free entries.
- Overflow: a push with the queue full sets error code 2. qed_err_rd_o gets the original's rd, and the entry is dropped.
- Orphan: a pop with no available entry (including the second pop when only one is queued) sets error code 3.
- Mismatch sets error code 1. qed_err_rd_o gets the duplicate's rd.
- Error latency: flags are registered, visible the cycle after the offending retire edge.
- Only the first error is captured. Later errors do not change code or rd until clear_i or reset.
- Checking continues after an error. The queue still advances, so pending_o stays meaningful.
- Priority when two errors occur in one cycle: slot 0's error wins.
- Queue storage:
  - Circular buffer with wrapping read/write pointers of $clog2(DEPTH) bits.
  - Count register of $clog2(DEPTH)+1 bits, so DEPTH entries are distinguishable from empty.
  - Pointers advance by 0, 1 or 2 modulo DEPTH.
- pending_o and qed_consistent_o are registered and reflect state after the last edge.

Decomposition:
- Shared qed package:
  - constants for the duplicate register bit (bit 4) and ORIG_RD_MASK 4'hF;
  - the error-code enum (QED_ERR_NONE/MISMATCH/OVERFLOW/ORPHAN);
  - the queue-entry struct {rd[3:0], data[XLEN-1:0]}.
- One sub-module, qed_pending_fifo: a 2-push/2-pop circular buffer exposing head, head+1, free count and count.
- Classification, bypass and error capture stay in the top level.

Test Plan:
- Reset, then slot 0 writes x5=0x1234, next cycle slot 0 writes x21=0x1234 → pending 1 then 0, error 0, consistent 1.
- Slot 0 x3=0xA, slot 1 x19=0xB in the same cycle → one cycle later error=1, code=1, rd=19, pending 0.
- Fill 8 originals x1..x8, then a ninth original x9 → code=2, rd=9, pending stays 8. Then 8 matching duplicates x17..x24 → pending 0, error remains 1, code remains 2.
- Empty queue, slot 0 duplicate x20 → code=3, rd=20. Then clear_i → error 0, code 0, consistent 1.
- Queue holds one entry x2=7, both slots duplicates x18=7 and x18=7 → first compare passes, second reports orphan, code=3.
- Push x4=1, then drop qed_ena_i low, then duplicate x20=9 → ignored, pending 1, no error. Assert rst_ni low mid-stream → pending 0, all outputs reset values.

Source files
------------

// File: rtl/qed_writeback_checker_pkg.sv
// Shared QED writeback-checker types: error codes, queue entry layout and
// register-class constants used by the checker and its pending-original queue.
package qed_writeback_checker_pkg;

  localparam int         QED_DUP_BIT  = 4;
  localparam logic [3:0] ORIG_RD_MASK = 4'hF;
  // Entry data field is sized for the widest supported XLEN; narrower
  // writebacks are zero-extended so compares stay exact.
  localparam int         QED_DATA_W   = 64;

  typedef enum logic [1:0] {
    QED_ERR_NONE     = 2'd0,
    QED_ERR_MISMATCH = 2'd1,
    QED_ERR_OVERFLOW = 2'd2,
    QED_ERR_ORPHAN   = 2'd3
  } qed_err_e;

  typedef struct packed {
    logic [3:0]            rd;
    logic [QED_DATA_W-1:0] data;
  } qed_entry_t;

  function automatic qed_entry_t qed_mk_entry(input logic [4:0] rd,
                                              input logic [QED_DATA_W-1:0] data);
    qed_entry_t e;
    e.rd   = rd[3:0] & ORIG_RD_MASK;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/qed_writeback_checker_pending_fifo.sv
// Circular buffer of pending original writebacks; accepts up to two pushes
// and two pops per cycle and exposes the two oldest entries.
module qed_pending_fifo
  import qed_writeback_checker_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [1:0]    push_n,
  input  qed_entry_t    push0,
  input  qed_entry_t    push1,
  input  logic [1:0]    pop_n,
  output qed_entry_t    head,
  output qed_entry_t    head1,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free
);

  qed_entry_t      mem [DEPTH];
  logic [PW-1:0]   rptr, wptr;

  assign head  = mem[rptr];
  assign head1 = mem[rptr + PW'(1)];
  assign free  = CW'(DEPTH) - count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      // Power-of-two depth: pointer truncation is the modulo wrap.
      wptr  <= wptr + PW'(push_n);
      rptr  <= rptr + PW'(pop_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear) begin
      if (push_n != 2'd0) mem[wptr] <= push0;
      if (push_n == 2'd2) mem[wptr + PW'(1)] <= push1;
    end
  end

endmodule

// File: rtl/qed_writeback_checker.sv
// End-of-chain QED checker: pairs each original writeback (x1..x15) with the
// next duplicate writeback (x16..x31) in program order, flagging the first error.
module qed_writeback_checker
  import qed_writeback_checker_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = CW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            qed_ena_i,
  input  logic            ret0_valid_i,
  input  logic [4:0]      ret0_rd_i,
  input  logic [XLEN-1:0] ret0_data_i,
  input  logic            ret1_valid_i,
  input  logic [4:0]      ret1_rd_i,
  input  logic [XLEN-1:0] ret1_data_i,
  input  logic            clear_i,
  output logic            qed_error_o,
  output logic [1:0]      qed_err_code_o,
  output logic [4:0]      qed_err_rd_o,
  output logic [CW-1:0]   pending_o,
  output logic            qed_consistent_o
);

  qed_entry_t    e0, e1, head, head1, push0, push1;
  logic [CW-1:0] count, free, cnt_nxt;
  logic [1:0]    push_n, pop_n;
  logic          orig0, dup0, orig1, dup1;
  qed_err_e      code0, code1, new_code, err_code_q;
  logic [4:0]    new_rd;

  assign e0 = qed_mk_entry(ret0_rd_i, QED_DATA_W'(ret0_data_i));
  assign e1 = qed_mk_entry(ret1_rd_i, QED_DATA_W'(ret1_data_i));

  assign orig0 = qed_ena_i && ret0_valid_i && (ret0_rd_i != 5'd0) && !ret0_rd_i[QED_DUP_BIT];
  assign dup0  = qed_ena_i && ret0_valid_i && ret0_rd_i[QED_DUP_BIT];
  assign orig1 = qed_ena_i && ret1_valid_i && (ret1_rd_i != 5'd0) && !ret1_rd_i[QED_DUP_BIT];
  assign dup1  = qed_ena_i && ret1_valid_i && ret1_rd_i[QED_DUP_BIT];

  // Slot 0 is resolved first; slot 1 then sees the queue as slot 0 left it.
  always_comb begin
    push_n = 2'd0;
    pop_n  = 2'd0;
    push0  = e0;
    push1  = e1;
    code0  = QED_ERR_NONE;
    code1  = QED_ERR_NONE;

    if (orig0) begin
      if (free != '0) push_n = 2'd1;
      else            code0  = QED_ERR_OVERFLOW;
    end else if (dup0) begin
      if (count != '0) begin
        pop_n = 2'd1;
        if (head != e0) code0 = QED_ERR_MISMATCH;
      end else begin
        code0 = QED_ERR_ORPHAN;
      end
    end

    if (orig1) begin
      if ((AW'(free) + AW'(pop_n)) > AW'(push_n)) begin
        if (push_n == 2'd0) push0 = e1;
        else                push1 = e1;
        push_n = push_n + 2'd1;
      end else begin
        code1 = QED_ERR_OVERFLOW;
      end
    end else if (dup1) begin
      if (push_n == 2'd1 && count == '0) begin
        // Pair retiring together into an empty queue: compare directly, store nothing.
        push_n = 2'd0;
        if (e0 != e1) code1 = QED_ERR_MISMATCH;
      end else if (pop_n == 2'd1) begin
        if (count >= CW'(2)) begin
          pop_n = 2'd2;
          if (head1 != e1) code1 = QED_ERR_MISMATCH;
        end else begin
          code1 = QED_ERR_ORPHAN;
        end
      end else if (count != '0) begin
        pop_n = 2'd1;
        if (head != e1) code1 = QED_ERR_MISMATCH;
      end else begin
        code1 = QED_ERR_ORPHAN;
      end
    end
  end

  assign new_code = (code0 != QED_ERR_NONE) ? code0 : code1;
  assign new_rd   = (code0 != QED_ERR_NONE) ? ret0_rd_i : ret1_rd_i;
  assign cnt_nxt  = count + CW'(push_n) - CW'(pop_n);

  qed_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (clear_i),
    .push_n (push_n),
    .push0  (push0),
    .push1  (push1),
    .pop_n  (pop_n),
    .head   (head),
    .head1  (head1),
    .count  (count),
    .free   (free)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      qed_error_o      <= 1'b0;
      err_code_q       <= QED_ERR_NONE;
      qed_err_rd_o     <= 5'd0;
      qed_consistent_o <= 1'b1;
    end else begin
      if (!qed_error_o && new_code != QED_ERR_NONE) begin
        qed_error_o  <= 1'b1;
        err_code_q   <= new_code;
        qed_err_rd_o <= new_rd;
      end
      qed_consistent_o <= (cnt_nxt == '0) && !qed_error_o && (new_code == QED_ERR_NONE);
    end
  end

  assign qed_err_code_o = err_code_q;
  assign pending_o      = count;

endmodule

// File: tb/tb_qed_writeback_checker.sv
// Directed plus randomized bench for qed_writeback_checker against a
// queue-based model that processes retire slots one at a time.
module tb_qed_writeback_checker;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b1;
  logic            v0 = 1'b0, v1 = 1'b0;
  logic [4:0]      rd0 = '0, rd1 = '0;
  logic [XLEN-1:0] d0 = '0, d1 = '0;
  logic            clr = 1'b0;
  logic            err;
  logic [1:0]      code;
  logic [4:0]      erd;
  logic [CW-1:0]   pend;
  logic            cons;

  int checks = 0;
  int errors = 0;

  logic [35:0] q[$];
  bit          merr;
  logic [1:0]  mcode;
  logic [4:0]  mrd;

  always #5 clk = ~clk;

  qed_writeback_checker #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .qed_ena_i(ena),
    .ret0_valid_i(v0), .ret0_rd_i(rd0), .ret0_data_i(d0),
    .ret1_valid_i(v1), .ret1_rd_i(rd1), .ret1_data_i(d1),
    .clear_i(clr), .qed_error_o(err), .qed_err_code_o(code),
    .qed_err_rd_o(erd), .pending_o(pend), .qed_consistent_o(cons)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flag(input logic [1:0] c, input logic [4:0] r);
    if (!merr) begin
      merr  = 1'b1;
      mcode = c;
      mrd   = r;
    end
  endtask

  // One retire slot, applied to the model in program order.
  task automatic proc(input logic v, input logic [4:0] r, input logic [31:0] d);
    logic [35:0] e;
    if (!v || r == 5'd0) return;
    if (!r[4]) begin
      if (q.size() < DEPTH) q.push_back({r[3:0], d});
      else                  flag(2'd2, r);
    end else if (q.size() == 0) begin
      flag(2'd3, r);
    end else begin
      e = q.pop_front();
      if (e != {r[3:0], d}) flag(2'd1, r);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".error"},   32'(err),  32'(merr));
    chk({tag, ".code"},    32'(code), 32'(mcode));
    chk({tag, ".rd"},      32'(erd),  32'(mrd));
    chk({tag, ".pending"}, 32'(pend), 32'(q.size()));
    chk({tag, ".consist"}, 32'(cons), 32'((q.size() == 0) && !merr));
  endtask

  task automatic cyc(input string tag,
                     input logic a0, input logic [4:0] r0, input logic [31:0] x0,
                     input logic a1, input logic [4:0] r1, input logic [31:0] x1,
                     input logic en, input logic cl, input logic rs);
    v0 = a0; rd0 = r0; d0 = x0;
    v1 = a1; rd1 = r1; d1 = x1;
    ena = en; clr = cl; rst_n = rs;
    @(posedge clk);
    if (!rs || cl) begin
      q.delete();
      merr = 1'b0; mcode = 2'd0; mrd = 5'd0;
    end else if (en) begin
      proc(a0, r0, x0);
      proc(a1, r1, x1);
    end
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 1, 0, 1);
  endtask

  task automatic do_clear(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 1, 1, 1);
  endtask

  // Random slot: mostly duplicates that mirror the model's head so matches occur.
  task automatic rnd_slot(output logic a, output logic [4:0] r, output logic [31:0] d);
    int k;
    k = $urandom_range(0, 9);
    a = (k >= 2);
    r = 5'(k == 2 ? 0 : $urandom_range(1, 31));
    d = $urandom_range(0, 3);
    if (k >= 3 && k <= 5) begin
      r = 5'($urandom_range(1, 15));
    end else if (k >= 6) begin
      if (q.size() != 0 && $urandom_range(0, 7) != 0) begin
        r = {1'b1, q[0][35:32]};
        d = q[0][31:0];
      end else begin
        r = 5'($urandom_range(16, 31));
      end
    end
  endtask

  initial begin
    logic a0, a1;
    logic [4:0] r0, r1;
    logic [31:0] x0, x1;
    merr = 1'b0; mcode = 2'd0; mrd = 5'd0;

    cyc("reset0", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("reset1", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("reset.pending", 32'(pend), 32'd0);
    chk("reset.consist", 32'(cons), 32'd1);

    cyc("tp1a", 1, 5'd5, 32'h1234, 0, 0, 0, 1, 0, 1);
    chk("tp1a.pend1", 32'(pend), 32'd1);
    cyc("tp1b", 1, 5'd21, 32'h1234, 0, 0, 0, 1, 0, 1);
    chk("tp1b.pend0", 32'(pend), 32'd0);
    chk("tp1b.cons", 32'(cons), 32'd1);

    cyc("tp2", 1, 5'd3, 32'hA, 1, 5'd19, 32'hB, 1, 0, 1);
    chk("tp2.code", 32'(code), 32'd1);
    chk("tp2.rd", 32'(erd), 32'd19);
    do_clear("tp2.clr");

    for (int i = 1; i <= 8; i++) cyc("tp3.fill", 1, 5'(i), 32'(i * 3), 0, 0, 0, 1, 0, 1);
    cyc("tp3.ovf", 1, 5'd9, 32'h99, 0, 0, 0, 1, 0, 1);
    chk("tp3.code", 32'(code), 32'd2);
    chk("tp3.rd", 32'(erd), 32'd9);
    chk("tp3.pend8", 32'(pend), 32'd8);
    for (int i = 1; i <= 8; i++) cyc("tp3.drain", 1, 5'(16 + i), 32'(i * 3), 0, 0, 0, 1, 0, 1);
    chk("tp3.pend0", 32'(pend), 32'd0);
    chk("tp3.sticky", 32'(code), 32'd2);
    do_clear("tp3.clr");

    cyc("tp4", 1, 5'd20, 32'h0, 0, 0, 0, 1, 0, 1);
    chk("tp4.code", 32'(code), 32'd3);
    chk("tp4.rd", 32'(erd), 32'd20);
    do_clear("tp4.clr");
    chk("tp4.clr_err", 32'(err), 32'd0);

    cyc("tp5a", 1, 5'd2, 32'd7, 0, 0, 0, 1, 0, 1);
    cyc("tp5b", 1, 5'd18, 32'd7, 1, 5'd18, 32'd7, 1, 0, 1);
    chk("tp5.code", 32'(code), 32'd3);
    chk("tp5.rd", 32'(erd), 32'd18);
    do_clear("tp5.clr");

    cyc("tp6a", 1, 5'd4, 32'd1, 0, 0, 0, 1, 0, 1);
    cyc("tp6b", 1, 5'd20, 32'd9, 0, 0, 0, 0, 0, 1);
    chk("tp6.pend1", 32'(pend), 32'd1);
    chk("tp6.noerr", 32'(err), 32'd0);
    cyc("tp6.rst", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("tp6.rst_pend", 32'(pend), 32'd0);
    idle("tp6.idle");

    // Dual push at DEPTH-1: first accepted, second overflows.
    for (int i = 1; i <= 7; i++) cyc("edge.fill", 1, 5'(i), 32'(i), 0, 0, 0, 1, 0, 1);
    cyc("edge.dual", 1, 5'd8, 32'd8, 1, 5'd9, 32'd9, 1, 0, 1);
    chk("edge.rd", 32'(erd), 32'd9);
    do_clear("edge.clr");

    for (int n = 0; n < 3000; n++) begin
      rnd_slot(a0, r0, x0);
      rnd_slot(a1, r1, x1);
      cyc("rand", a0, r0, x0, a1, r1, x1,
          ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 199) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
